mux_rr_nb: RTL

- Parametrised N:1 data-path multiplexer with a registered output and a valid/ready handshake on every input and on the output.
- Two selection modes:
  - Fixed mode: an external SEL port chooses the channel, as the combinational muxes do today.
  - Round-robin mode: the block arbitrates fairly among requesting channels.
- Sits between multiple producers (peripheral input ports, interrupt sources) and a single consumer on the RAT data path.

---
 rtl/mux_rr_nb_if.sv | 27 ++
 rtl/mux_rr_nb.sv | 76 +++++++
 2 files changed

// File: rtl/mux_rr_nb_if.sv
// Handshake bundle for mux_rr_nb: CH producer channels in, one consumer out.
// slave is the mux side, master is the producer/consumer side.
interface mux_rr_nb_if #(
    parameter int n  = 8,
    parameter int SW = 3
);
    localparam int CH = 2 ** SW;

    logic [SW-1:0]   SEL;
    logic [CH*n-1:0] D_IN;
    logic [CH-1:0]   VALID_IN;
    logic [CH-1:0]   READY_OUT;
    logic [n-1:0]    D_OUT;
    logic            VALID_OUT;
    logic            READY_IN;
    logic [SW-1:0]   GRANT_IDX;

    modport slave (
        input  SEL, D_IN, VALID_IN, READY_IN,
        output READY_OUT, D_OUT, VALID_OUT, GRANT_IDX
    );

    modport master (
        output SEL, D_IN, VALID_IN, READY_IN,
        input  READY_OUT, D_OUT, VALID_OUT, GRANT_IDX
    );
endinterface

// File: rtl/mux_rr_nb.sv
// N:1 registered mux with valid/ready on every channel.
// MODE=0 follows SEL, MODE=1 arbitrates round-robin from LAST+1.
module mux_rr_nb #(
    parameter int n    = 8,
    parameter int SW   = 3,
    parameter int MODE = 0
) (
    input  logic        CLK,
    input  logic        RST_N,
    mux_rr_nb_if.slave  bus
);
    localparam int CH = 2 ** SW;

    logic [SW-1:0] last;
    logic [SW-1:0] cand;
    logic [SW-1:0] idx;
    logic          req;
    logic          can_load;
    logic          accept;
    logic [CH-1:0] rdy;
    logic [n-1:0]  d_q;
    logic          v_q;
    logic [SW-1:0] g_q;

    always_comb begin
        cand = '0;
        req  = 1'b0;
        idx  = last;
        if (MODE == 0) begin
            cand = bus.SEL;
            req  = bus.VALID_IN[bus.SEL];
        end else begin
            // first requester at or after LAST+1, wrapping naturally
            for (int k = 0; k < CH; k++) begin
                idx = idx + SW'(1);
                if (!req && bus.VALID_IN[idx]) begin
                    req  = 1'b1;
                    cand = idx;
                end
            end
        end
    end

    assign can_load = !v_q || bus.READY_IN;
    assign accept   = RST_N && can_load && req;

    always_comb begin
        rdy = '0;
        for (int i = 0; i < CH; i++) begin
            rdy[i] = accept && (cand == SW'(i));
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            d_q  <= '0;
            v_q  <= 1'b0;
            g_q  <= '0;
            last <= SW'(CH - 1);
        end else if (accept) begin
            d_q <= bus.D_IN[cand*n +: n];
            g_q <= cand;
            v_q <= 1'b1;
            if (MODE == 1) begin
                last <= cand;
            end
        end else if (bus.READY_IN && v_q) begin
            v_q <= 1'b0;
        end
    end

    assign bus.READY_OUT = rdy;
    assign bus.D_OUT     = d_q;
    assign bus.VALID_OUT = v_q;
    assign bus.GRANT_IDX = g_q;
endmodule
